// File: rtl/seg7_capture_decoder.sv
// Multiplexed seven-segment bus sniffer: it filters mux ghosting, decodes each digit
// and delivers whole frames over valid/ready. Define SEG7_ACTIVE_LOW_EN for common-anode inputs.
module seg7_capture_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    err_pat,
    output logic                    err_sel,
    output logic                    overflow,
    output logic                    dbg_state
);

    // Handshake: frame_data is held while frame_valid is high; a frame is consumed on any
    // clock edge with frame_valid && frame_ready. frame_ready is ignored while frame_valid is low.

    localparam int SW = NUM_DIGITS + 7;
    localparam int CW = 8;

    typedef enum logic {TRACK = 1'b0, LOCKED = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           smp_q, smp_d;
    logic [SW-1:0]           smp_dly_q, smp_dly_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [4*NUM_DIGITS-1:0] frame_data_q, frame_data_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    err_pat_q, err_pat_d;
    logic                    err_sel_q, err_sel_d;
    logic                    overflow_q, overflow_d;

    logic                    accept;
    logic                    complete;
    logic [NUM_DIGITS-1:0]   smp_an;
    logic [6:0]              smp_seg;
    logic [4:0]              dec;

    // Returns {invalid, code}; unknown patterns map to 4'hE.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1111110: decode = 5'h00;
            7'b0110000: decode = 5'h01;
            7'b1101101: decode = 5'h02;
            7'b1111001: decode = 5'h03;
            7'b0110011: decode = 5'h04;
            7'b1011011: decode = 5'h05;
            7'b1011111: decode = 5'h06;
            7'b1110000: decode = 5'h07;
            7'b1111111: decode = 5'h08;
            7'b1111011: decode = 5'h09;
            7'b0000000: decode = 5'h0F;
            default:    decode = 5'h1E;
        endcase
    endfunction

    always_comb begin
`ifdef SEG7_ACTIVE_LOW_EN
        smp_d = ~{an, seg};
`else
        smp_d = {an, seg};
`endif
        smp_dly_d = smp_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;

        if (smp_q != smp_dly_q) begin
            cnt_d   = '0;
            state_d = TRACK;
        end else if (state_q == TRACK) begin
            if (cnt_q < CW'(STABLE_CYCLES - 1)) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q == CW'(STABLE_CYCLES - 2)) begin
                accept  = 1'b1;
                state_d = LOCKED;
            end
        end

        smp_an    = smp_q[SW-1:7];
        smp_seg   = smp_q[6:0];
        dec       = decode(smp_seg);
        digits_d  = digits_q;
        seen_d    = seen_q;
        err_pat_d = 1'b0;
        err_sel_d = 1'b0;
        complete  = &seen_q;

        // A completed mask is cleared one edge after its last write; no accept can land here.
        if (complete) begin
            seen_d = '0;
        end

        if (accept && (smp_an != '0)) begin
            if ((smp_an & (smp_an - NUM_DIGITS'(1))) == '0) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (smp_an[i]) begin
                        digits_d[4*i +: 4] = dec[3:0];
                        seen_d[i]          = 1'b1;
                    end
                end
                err_pat_d = dec[4];
            end else begin
                err_sel_d = 1'b1;
            end
        end

        frame_data_d  = frame_data_q;
        frame_valid_d = frame_valid_q;
        overflow_d    = overflow_q;

        // A frame completing under a pending unconsumed frame is dropped.
        if (complete) begin
            if (!frame_valid_q || frame_ready) begin
                frame_data_d  = digits_q;
                frame_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (frame_valid_q && frame_ready) begin
            frame_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= TRACK;
            smp_q         <= '0;
            smp_dly_q     <= '0;
            cnt_q         <= '0;
            seen_q        <= '0;
            digits_q      <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            err_pat_q     <= 1'b0;
            err_sel_q     <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            smp_q         <= smp_d;
            smp_dly_q     <= smp_dly_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            err_pat_q     <= err_pat_d;
            err_sel_q     <= err_sel_d;
            overflow_q    <= overflow_d;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign err_pat     = err_pat_q;
    assign err_sel     = err_sel_q;
    assign overflow    = overflow_q;
    assign dbg_state   = state_q;

endmodule
